// File: rtl/fifo_rr_drain.sv
// Round-robin, packet-aware scheduler that drains NIN upstream FIFOs into one
// registered valid/ready stream, holding each grant until end-of-packet is read.
module fifo_rr_drain #(
    parameter int LGNIN = 2,
    parameter int BW    = 64
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [(1<<LGNIN)-1:0]      i_empty,
    input  logic [(1<<LGNIN)*BW-1:0]   i_data,
    input  logic [(1<<LGNIN)-1:0]      i_last,
    output logic [(1<<LGNIN)-1:0]      o_rd,
    output logic                       M_VALID,
    input  logic                       M_READY,
    output logic [BW-1:0]              M_DATA,
    output logic                       M_LAST,
    output logic [LGNIN-1:0]           M_CHAN,
    output logic                       o_busy
);
    localparam int NIN = 1 << LGNIN;

    // Handshake: a word moves downstream on a cycle where M_VALID && M_READY;
    // M_DATA/M_LAST/M_CHAN are held stable while M_VALID && !M_READY.
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nx;
    logic [LGNIN-1:0] grant, last_grant;
    logic [LGNIN-1:0] pick, idx;
    logic             found;
    logic             advance, rd_en;
    logic [BW-1:0]    head_data;
    logic             head_last;

    // Scan starts just after the previous grant so every FIFO gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        idx   = '0;
        for (int k = 1; k <= NIN; k++) begin
            idx = last_grant + LGNIN'(k);
            if (!found && !i_empty[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign head_data = i_data[grant*BW +: BW];
    assign head_last = i_last[grant];
    assign advance   = !M_VALID || M_READY;
    assign rd_en     = (state == ACTIVE) && advance && !i_empty[grant] && !i_reset;
    assign o_busy    = (state == ACTIVE);

    always_comb begin
        state_nx = state;
        o_rd     = '0;
        case (state)
            IDLE: begin
                if (found) state_nx = ACTIVE;
            end
            ACTIVE: begin
                if (rd_en) begin
                    o_rd[grant] = 1'b1;
                    if (head_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= '1;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            M_VALID <= 1'b0;
            M_DATA  <= '0;
            M_LAST  <= 1'b0;
            M_CHAN  <= '0;
        end else if (rd_en) begin
            M_VALID <= 1'b1;
            M_DATA  <= head_data;
            M_LAST  <= head_last;
            M_CHAN  <= grant;
        end else if (advance) begin
            M_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: behavioural upstream FIFOs, expected-word queue
// scoreboard on the output stream, and read-pattern checks per scenario.
module tb_fifo_rr_drain;
    localparam int LGNIN = 2;
    localparam int BW    = 64;
    localparam int NIN   = 4;
    localparam int W     = BW + 1 + LGNIN;
    localparam int DEPTH = 16;

    logic                i_clk;
    logic                i_reset;
    logic [NIN-1:0]      i_empty;
    logic [NIN*BW-1:0]   i_data;
    logic [NIN-1:0]      i_last;
    logic [NIN-1:0]      o_rd;
    logic                M_VALID;
    logic                M_READY;
    logic [BW-1:0]       M_DATA;
    logic                M_LAST;
    logic [LGNIN-1:0]    M_CHAN;
    logic                o_busy;

    fifo_rr_drain #(.LGNIN(LGNIN), .BW(BW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_empty(i_empty), .i_data(i_data),
        .i_last(i_last), .o_rd(o_rd), .M_VALID(M_VALID), .M_READY(M_READY),
        .M_DATA(M_DATA), .M_LAST(M_LAST), .M_CHAN(M_CHAN), .o_busy(o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [BW:0]   fmem [NIN][DEPTH];
    int            wp [NIN];
    int            rp [NIN];
    logic [W-1:0]  exp_q[$];
    int            rd_cyc[$];
    int            rd_fifo[$];
    int            errors, checks, cyc, stalls;
    logic [NIN-1:0] s_rd;
    logic          s_mv, s_mr, s_busy, prev_stall;
    logic [W-1:0]  s_out, prev_out;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int n, input logic [BW-1:0] data, input logic last);
        fmem[n][wp[n] % DEPTH] = {last, data};
        wp[n]++;
    endtask

    task automatic expect_word(input int chan, input logic [BW-1:0] data, input logic last);
        exp_q.push_back({LGNIN'(chan), last, data});
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int n = 0; n < NIN; n++) if (wp[n] != rp[n]) p = 1'b1;
        return p;
    endfunction

    task automatic refresh();
        for (int n = 0; n < NIN; n++) begin
            i_empty[n]          = (wp[n] == rp[n]);
            i_data[n*BW +: BW]  = fmem[n][rp[n] % DEPTH][BW-1:0];
            i_last[n]           = fmem[n][rp[n] % DEPTH][BW];
        end
    endtask

    // One clock: sample at the falling edge, model FIFO pops after the rising edge.
    task automatic cycle();
        refresh();
        @(negedge i_clk);
        s_rd   = o_rd;
        s_mv   = M_VALID;
        s_mr   = M_READY;
        s_busy = o_busy;
        s_out  = {M_CHAN, M_LAST, M_DATA};
        if (i_reset) check("rst_rd", W'(s_rd), '0);
        check("rd_onehot", W'($onehot0(s_rd)), W'(1));
        for (int n = 0; n < NIN; n++) begin
            if (s_rd[n]) begin
                check("rd_nonempty", W'(wp[n] != rp[n]), W'(1));
                rd_cyc.push_back(cyc);
                rd_fifo.push_back(n);
            end
        end
        if (prev_stall) begin
            check("stall_hold", s_out, prev_out);
            check("stall_valid", W'(s_mv), W'(1));
        end
        if (s_mv && !s_mr) begin
            stalls++;
            check("stall_rd", W'(s_rd), '0);
        end
        if (s_mv && s_mr) begin
            if (exp_q.size() == 0) check("unexpected_word", s_out, 'x);
            else check("out_word", s_out, exp_q.pop_front());
        end
        prev_stall = s_mv && !s_mr && !i_reset;
        prev_out   = s_out;
        @(posedge i_clk);
        #1;
        for (int n = 0; n < NIN; n++) if (s_rd[n] && wp[n] != rp[n]) rp[n]++;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || pending()) && k < budget) begin
            cycle();
            k++;
        end
        check("drained", W'(exp_q.size()), '0);
        cycle();
        check("idle_busy", W'(s_busy), '0);
        check("idle_valid", W'(s_mv), '0);
    endtask

    task automatic flush_model();
        for (int n = 0; n < NIN; n++) rp[n] = wp[n];
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cycle();
        cycle();
        i_reset = 1'b0;
        flush_model();
        prev_stall = 1'b0;
    endtask

    initial begin
        logic ready_pat [4];
        int   k;
        errors = 0; checks = 0; cyc = 0; stalls = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int n = 0; n < NIN; n++) begin
            wp[n] = 0;
            rp[n] = 0;
        end
        i_reset = 1'b1;
        M_READY = 1'b1;
        ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;

        // Reset values
        do_reset();
        check("rst_valid", W'(s_mv), '0);
        check("rst_out", s_out, '0);
        check("rst_busy", W'(s_busy), '0);

        // Single 3-word packet from FIFO 2
        load(2, 64'hA0, 1'b0); load(2, 64'hA1, 1'b0); load(2, 64'hA2, 1'b1);
        expect_word(2, 64'hA0, 1'b0); expect_word(2, 64'hA1, 1'b0); expect_word(2, 64'hA2, 1'b1);
        rd_cyc.delete(); rd_fifo.delete();
        drain(30);
        check("single_reads", W'(rd_fifo.size()), W'(3));
        if (rd_fifo.size() == 3) begin
            for (int i = 0; i < 3; i++) check("single_fifo", W'(rd_fifo[i]), W'(2));
            check("single_gap1", W'(rd_cyc[1] - rd_cyc[0]), W'(1));
            check("single_gap2", W'(rd_cyc[2] - rd_cyc[1]), W'(1));
        end

        // Fairness: two 1-word packets per FIFO
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int n = 0; n < NIN; n++) begin
                load(n, BW'(64'hB000 + n*2 + p), 1'b1);
                expect_word(n, BW'(64'hB000 + n*2 + p), 1'b1);
            end
        rd_cyc.delete(); rd_fifo.delete();
        drain(60);
        check("fair_reads", W'(rd_fifo.size()), W'(8));
        if (rd_fifo.size() == 8) begin
            for (int i = 0; i < 8; i++) check("fair_order", W'(rd_fifo[i]), W'(i % 4));
            for (int i = 1; i < 8; i++) check("fair_bubble", W'(rd_cyc[i] - rd_cyc[i-1]), W'(2));
        end

        // Backpressure during a 5-word packet from FIFO 0
        for (int i = 0; i < 5; i++) begin
            load(0, BW'(64'hC100 + i), i == 4);
            expect_word(0, BW'(64'hC100 + i), i == 4);
        end
        stalls = 0;
        k = 0;
        while ((exp_q.size() != 0 || pending()) && k < 80) begin
            M_READY = ready_pat[k % 4];
            cycle();
            k++;
        end
        M_READY = 1'b1;
        check("bp_drained", W'(exp_q.size()), '0);
        check("bp_stalls_seen", W'(stalls > 0), W'(1));
        cycle();
        check("bp_idle", W'(s_busy), '0);

        // Mid-packet underflow on FIFO 1 while FIFO 3 waits
        load(1, 64'hD0, 1'b0); load(1, 64'hD1, 1'b0);
        load(3, 64'hE0, 1'b1);
        expect_word(1, 64'hD0, 1'b0); expect_word(1, 64'hD1, 1'b0);
        rd_cyc.delete(); rd_fifo.delete();
        for (int i = 0; i < 10; i++) cycle();
        check("uf_reads", W'(rd_fifo.size()), W'(2));
        check("uf_no_fifo3", W'(rd_fifo.size() == 2 && rd_fifo[0] == 1 && rd_fifo[1] == 1), W'(1));
        check("uf_busy", W'(s_busy), W'(1));
        load(1, 64'hD2, 1'b0); load(1, 64'hD3, 1'b1);
        expect_word(1, 64'hD2, 1'b0); expect_word(1, 64'hD3, 1'b1); expect_word(3, 64'hE0, 1'b1);
        drain(40);
        check("uf_total", W'(rd_fifo.size()), W'(5));
        if (rd_fifo.size() == 5) check("uf_then3", W'(rd_fifo[4]), W'(3));

        // Reset during word 2 of a 4-word packet
        for (int i = 0; i < 4; i++) load(1, BW'(64'hF10 + i), i == 3);
        expect_word(1, 64'hF10, 1'b0);
        rd_cyc.delete(); rd_fifo.delete();
        k = 0;
        while (rd_fifo.size() < 1 && k < 10) begin
            cycle();
            k++;
        end
        check("mr_first_read", W'(rd_fifo.size()), W'(1));
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        flush_model();
        prev_stall = 1'b0;
        cycle();
        check("mr_valid", W'(s_mv), '0);
        check("mr_busy", W'(s_busy), '0);
        check("mr_rd", W'(s_rd), '0);
        check("mr_sb_empty", W'(exp_q.size()), '0);
        for (int n = 0; n < NIN; n++) begin
            load(n, BW'(64'hF200 + n), 1'b1);
            expect_word(n, BW'(64'hF200 + n), 1'b1);
        end
        rd_cyc.delete(); rd_fifo.delete();
        drain(40);
        if (rd_fifo.size() > 0) check("mr_first_grant", W'(rd_fifo[0]), '0);
        else check("mr_first_grant", W'(-1), '0);

        // Wrap-around: last grant 3, only FIFO 3 requesting
        load(3, 64'h9300, 1'b1);
        expect_word(3, 64'h9300, 1'b1);
        rd_cyc.delete(); rd_fifo.delete();
        drain(20);
        check("wrap_regrant", W'(rd_fifo.size() == 1 && rd_fifo[0] == 3), W'(1));
        load(3, 64'h9301, 1'b1);
        load(0, 64'h9000, 1'b1);
        expect_word(0, 64'h9000, 1'b1);
        expect_word(3, 64'h9301, 1'b1);
        rd_cyc.delete(); rd_fifo.delete();
        drain(20);
        check("wrap_order", W'(rd_fifo.size() == 2 && rd_fifo[0] == 0 && rd_fifo[1] == 3), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin, packet-aware read scheduler that drains several upstream synchronous FIFOs into one shared valid/ready output stream. Each upstream FIFO presents its head word combinationally whenever it is not empty and advances on a one-cycle read strobe. The block holds a grant on one FIFO until that FIFO's end-of-packet word has been read, so packets never interleave. It sits between per-port receive FIFOs and a shared switch/egress datapath.

## Interface

Parameters:

- LGNIN, 2, log2 of the number of upstream FIFOs; NIN = 1<<LGNIN.
- BW, 64, data width per word, excluding the last flag.

Ports:

- i_clk  input  1  clock.
- i_reset  input  1  reset, synchronous, active-high.
- i_empty  input  NIN  per-FIFO empty flag; bit n belongs to FIFO n.
- i_data  input  NIN*BW  per-FIFO head data; FIFO n occupies bits [n*BW +: BW].
- i_last  input  NIN  per-FIFO head-word end-of-packet flag.
- o_rd  output  NIN  per-FIFO read strobe; one-hot or zero.
- M_VALID  output  1  output word valid.
- M_READY  input  1  downstream accept.
- M_DATA  output  BW  output word.
- M_LAST  output  1  output end-of-packet flag.
- M_CHAN  output  LGNIN  source FIFO index of the current output word.
- o_busy  output  1  high while in ACTIVE (a grant is held).

## Operation

- States: IDLE and ACTIVE. Registers: grant[LGNIN-1:0] and last_grant[LGNIN-1:0].
- IDLE:
  - If any i_empty bit is 0, select the first non-empty FIFO scanning last_grant+1, last_grant+2, … with modulo-NIN wrap.
  - Register the selection into grant and last_grant, then go to ACTIVE.
  - o_rd = 0 throughout IDLE.
- ACTIVE:
  - Define advance = !M_VALID || M_READY.
  - o_rd[grant] = advance && !i_empty[grant]. All other o_rd bits are 0.
  - On a read, the output register loads M_DATA <= i_data[grant], M_LAST <= i_last[grant], M_CHAN <= grant, and sets M_VALID <= 1.
  - If the word read has i_last = 1, return to IDLE on the next cycle.
  - If the granted FIFO empties mid-packet, hold the grant and stall; no timeout.
- Output register:
  - When advance is true and no read occurs, M_VALID <= 0.
  - While M_VALID && !M_READY, M_DATA, M_LAST and M_CHAN hold stable.
- No bits of i_data or i_last from non-granted FIFOs are ever consumed.
- Reset:
  - State = IDLE, last_grant = NIN-1 (so FIFO 0 has first priority), grant = 0.
  - M_VALID = 0, M_DATA = 0, M_LAST = 0, M_CHAN = 0, o_busy = 0, o_rd = 0.
  - Reset takes effect on any cycle, including mid-packet; a partially drained packet is abandoned.
  - During the reset cycle o_rd must be 0.
- Round-robin index arithmetic is LGNIN bits wide and wraps naturally at NIN.

## Timing

- Arbitration latency:
  - Non-empty seen in IDLE at cycle t: ACTIVE and the first o_rd at t+1.
  - M_VALID at t+2.
- Throughput: with M_READY held high and the granted FIFO non-empty, one word per cycle.
- Packet boundary: the last-word read at cycle t gives IDLE at t+1 and the next grant's first read at t+2. This is exactly one read-free cycle between packets.
- Backpressure: if M_READY is 0 while M_VALID is 1, o_rd goes 0 in that same cycle (combinational), so no word is lost or duplicated.
- Single-word packet (i_last set on the first word): ACTIVE lasts one read cycle.
- A FIFO that becomes non-empty during another FIFO's packet is considered only at the next IDLE cycle.

## Test plan

- Single packet: FIFO 2 holds 3 words, data 0xA0, 0xA1, 0xA2, with last on 0xA2; M_READY = 1.
  - o_rd[2] pulses on 3 consecutive cycles.
  - M_DATA is A0, A1, A2 with M_CHAN = 2 and M_LAST high only on A2.
  - o_busy then falls.
- Fairness: all 4 FIFOs each hold two 1-word packets.
  - Output channel order is 0, 1, 2, 3, 0, 1, 2, 3.
  - Exactly one bubble cycle between packets.
- Backpressure: M_READY toggles 1, 0, 0, 1 during a 5-word packet.
  - M_DATA is stable while stalled.
  - o_rd is 0 on the stalled cycles.
  - All 5 words arrive in order with no duplicates.
- Mid-packet underflow: FIFO 1 runs empty after 2 of 4 words while FIFO 3 is non-empty.
  - The grant stays on 1, and o_rd[3] stays 0.
  - The remaining 2 words from FIFO 1 follow when it refills, then FIFO 3 is granted.
- Reset mid-packet: assert i_reset during word 2 of a 4-word packet.
  - Next cycle: M_VALID = 0, o_busy = 0, o_rd = 0.
  - With all FIFOs non-empty afterwards, FIFO 0 is granted first.
- Wrap-around: last_grant = 3 and only FIFO 3 is non-empty.
  - FIFO 3 is re-granted.
  - Then, with FIFOs 0 and 3 non-empty, FIFO 0 is granted before FIFO 3.
